// File: rtl/vliw_ctrl_pkg.sv
// Shared types for the VLIW front-end control blocks: redirect FSM states,
// slot-count default and the fetch address type.
package vliw_ctrl_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned NUM_SLOTS_DEF = 4;
    localparam int unsigned SQ_CNT_W      = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } state_e;

    // Index width for an n-entry select; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_arbiter.sv
// Fixed-priority arbiter: lowest request index wins (program order in a bundle).
// Produces a one-hot grant and the binary index of the winner.
module prio_arbiter
    import vliw_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int unsigned IDX_W     = idx_width(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] req_i,
    output logic [NUM_SLOTS-1:0] grant_c_o,
    output logic [IDX_W-1:0]     idx_c_o
);

    // Scan from the highest slot down so the lowest requester is assigned last.
    always_comb begin
        grant_c_o = '0;
        idx_c_o   = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_c_o    = '0;
                grant_c_o[i] = 1'b1;
                idx_c_o      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: picks the oldest taken branch in a bundle,
// pulses a one-cycle PC redirect, and holds squash for SQUASH_CYCLES cycles.
// Optional build macro BRANCH_REDIRECT_PERF_EN adds a 32-bit redirect counter.
module branch_redirect_ctrl
    import vliw_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SLOTS     = NUM_SLOTS_DEF,
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SLOTS-1:0]              br_req,
    input  logic [NUM_SLOTS-1:0][ADDR_W-1:0]  br_target,
    input  logic                              hazard_stall,
    output logic                              branch_taken,
    output logic [ADDR_W-1:0]                 new_pc,
    output logic                              pc_stall,
    output logic                              squash,
    output logic                              busy
`ifdef BRANCH_REDIRECT_PERF_EN
   ,output logic [31:0]                       redirect_count
`endif
);

    localparam int unsigned IDX_W = idx_width(NUM_SLOTS);

    state_e                state_q;
    logic [SQ_CNT_W-1:0]   cnt_q;
    addr_t                 new_pc_q;
    logic                  branch_taken_q;
    logic                  pc_stall_q;
    logic                  squash_q;
    logic                  busy_q;

    logic [NUM_SLOTS-1:0]  arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  req_any_c;
    addr_t                 tgt_d;

    prio_arbiter #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req_i     (br_req),
        .grant_c_o (arb_grant),
        .idx_c_o   (arb_idx)
    );

    assign req_any_c = |arb_grant;
    assign tgt_d     = br_target[arb_idx];

    // Redirect FSM; every output is computed for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            new_pc_q       <= '0;
            branch_taken_q <= 1'b0;
            pc_stall_q     <= 1'b0;
            squash_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            branch_taken_q <= 1'b0;
            pc_stall_q     <= hazard_stall;
            squash_q       <= 1'b0;
            busy_q         <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_any_c) begin
                        state_q        <= ST_REDIRECT;
                        new_pc_q       <= tgt_d;
                        cnt_q          <= SQ_CNT_W'(SQUASH_CYCLES - 1);
                        branch_taken_q <= 1'b1;
                        pc_stall_q     <= 1'b0;
                        squash_q       <= 1'b1;
                        busy_q         <= 1'b1;
                    end
                end
                // cnt_q holds the squash cycles still owed after the current one.
                ST_REDIRECT, ST_SQUASH: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q  <= ST_SQUASH;
                        cnt_q    <= cnt_q - SQ_CNT_W'(1);
                        squash_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign branch_taken = branch_taken_q;
    assign new_pc       = new_pc_q;
    assign pc_stall     = pc_stall_q;
    assign squash       = squash_q;
    assign busy         = busy_q;

`ifdef BRANCH_REDIRECT_PERF_EN
    logic [31:0] redirect_count_q;

    // Count redirects; bumps on acceptance so it is current in the REDIRECT cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            redirect_count_q <= '0;
        end else if (state_q == ST_IDLE && req_any_c) begin
            redirect_count_q <= redirect_count_q + 32'd1;
        end
    end

    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: a cycle-indexed reference model
// pushes expected outputs per edge; a monitor pops and compares after each edge.
module tb_branch_redirect_ctrl;

    localparam int NS = 4;
    localparam int SQ = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NS-1:0]         br_req;
    logic [NS-1:0][31:0]   br_target;
    logic                  hazard_stall;
    logic                  branch_taken;
    logic [31:0]           new_pc;
    logic                  pc_stall;
    logic                  squash;
    logic                  busy;
`ifdef BRANCH_REDIRECT_PERF_EN
    logic [31:0]           redirect_count;
`endif

    branch_redirect_ctrl #(
        .NUM_SLOTS     (NS),
        .SQUASH_CYCLES (SQ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .br_req       (br_req),
        .br_target    (br_target),
        .hazard_stall (hazard_stall),
        .branch_taken (branch_taken),
        .new_pc       (new_pc),
        .pc_stall     (pc_stall),
        .squash       (squash),
        .busy         (busy)
`ifdef BRANCH_REDIRECT_PERF_EN
       ,.redirect_count (redirect_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bt;
        logic [31:0] pc;
        logic        ps;
        logic        sq;
        logic        by;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model state: cycle numbers of the latest redirect and of the
    // first idle cycle after its squash window.
    int          m_cyc = 0;
    int          m_redir = -100;
    int          m_free = 0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_cnt = '0;
    exp_t        m_e;
    int          m_c;

    function automatic int lowest_slot(input logic [NS-1:0] q);
        for (int i = 0; i < NS; i++) if (q[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst !== 1'b1) begin
            m_redir = -100;
            m_free  = 0;
            m_pc    = '0;
            m_cnt   = '0;
            m_e     = '0;
        end else begin
            if (m_cyc >= m_free && br_req != '0) begin
                m_redir = m_cyc + 1;
                m_free  = m_redir + SQ;
                m_pc    = br_target[lowest_slot(br_req)];
                m_cnt   = m_cnt + 32'd1;
            end
            m_c     = m_cyc + 1;
            m_e.bt  = (m_c == m_redir);
            m_e.sq  = (m_c >= m_redir) && (m_c < m_free);
            m_e.by  = m_e.sq;
            m_e.ps  = (m_c == m_redir) ? 1'b0 : hazard_stall;
            m_e.pc  = m_pc;
            m_e.cnt = m_cnt;
        end
        exp_q.push_back(m_e);
        m_cyc = m_cyc + 1;
    end

    task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc, got, want);
    endtask

    // Monitor: one output set per clock, compared just after the edge.
    initial begin : monitor
        exp_t e;
        int   mc;
        mc = 0;
        forever begin
            @(posedge clk);
            #1;
            mc++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard_empty cycle=%0d got=0 expected=1", mc);
            end else begin
                e = exp_q.pop_front();
                check("branch_taken", mc, 32'(branch_taken), 32'(e.bt));
                check("new_pc",       mc, new_pc,            e.pc);
                check("pc_stall",     mc, 32'(pc_stall),     32'(e.ps));
                check("squash",       mc, 32'(squash),       32'(e.sq));
                check("busy",         mc, 32'(busy),         32'(e.by));
`ifdef BRANCH_REDIRECT_PERF_EN
                check("redirect_count", mc, redirect_count, e.cnt);
`endif
            end
        end
    end

    task automatic step(input logic r, input logic [NS-1:0] q, input logic [NS-1:0][31:0] t, input logic h);
        @(negedge clk);
        rst          = r;
        br_req       = q;
        br_target    = t;
        hazard_stall = h;
    endtask

    initial begin : stim
        logic [NS-1:0][31:0] t;
        logic [NS-1:0]       q;
        rst = 1'b0; br_req = '0; br_target = '0; hazard_stall = 1'b0;
        t = '0;
        repeat (3) step(1'b0, '0, t, 1'b0);
        repeat (2) step(1'b1, '0, t, 1'b0);

        // single slot-2 redirect to 0x100
        t = '0; t[2] = 32'h0000_0100;
        step(1'b1, 4'b0100, t, 1'b0);
        repeat (4) step(1'b1, '0, t, 1'b0);

        // slots 1 and 3 together: slot 1 wins
        t = '0; t[1] = 32'h0000_0200; t[3] = 32'h0000_0800;
        step(1'b1, 4'b1010, t, 1'b0);
        repeat (4) step(1'b1, '0, t, 1'b0);

        // request held through redirect and squash
        t = '0; t[0] = 32'h0000_0340;
        repeat (8) step(1'b1, 4'b0001, t, 1'b0);
        repeat (3) step(1'b1, '0, t, 1'b0);

        // hazard stall concurrent with a redirect
        t[0] = 32'h0000_0480;
        step(1'b1, 4'b0001, t, 1'b1);
        repeat (3) step(1'b1, '0, t, 1'b1);
        repeat (2) step(1'b1, '0, t, 1'b0);

        // reset in the REDIRECT cycle
        t[0] = 32'h0000_0500;
        step(1'b1, 4'b0001, t, 1'b0);
        step(1'b0, '0, t, 1'b0);
        repeat (3) step(1'b1, '0, t, 1'b0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NS; i++) t[i] = $urandom;
            q = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
            step(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1, q, t, 1'($urandom));
        end

        repeat (3) step(1'b1, '0, t, 1'b0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, default 4: issue slots per bundle that can request a redirect.
REQ-002 Parameter SQUASH_CYCLES, default 2: cycles squash is held after a redirect (range 1..7).
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-low.
REQ-005 Port br_req  input  NUM_SLOTS: per-slot branch-taken request from branch execute.
REQ-006 Port br_target  input  NUM_SLOTS x 32: per-slot redirect target address.
REQ-007 Port hazard_stall  input  1: fetch stall request from the hazard/memory logic.
REQ-008 Port branch_taken  output  1: redirect strobe to the program counter.
REQ-009 Port new_pc  output  32: redirect target to the program counter.
REQ-010 Port pc_stall  output  1: stall to the program counter.
REQ-011 Port squash  output  1: squash to the ID/EX and EX/WB pipeline registers of all slots.
REQ-012 Port busy  output  1: high while the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, REDIRECT and SQUASH, encoded in the shared package.
REQ-014 In IDLE with any br_req bit set, the FSM SHALL latch the winning target and go to REDIRECT on the next edge.
REQ-015 Arbitration SHALL be fixed priority, lowest slot index first (program order within a bundle).
REQ-016 Requests from losing slots SHALL be discarded, not queued.
REQ-017 In REDIRECT, branch_taken SHALL be 1 for exactly one cycle, with new_pc equal to the latched target; the FSM then goes to SQUASH.
REQ-018 squash SHALL be 1 during the REDIRECT cycle and the following SQUASH_CYCLES-1 cycles (SQUASH_CYCLES cycles total).
REQ-019 A 3-bit down-counter SHALL time the squash window; the FSM SHALL return to IDLE when it reaches zero.
REQ-020 br_req SHALL be ignored in REDIRECT and SQUASH, because those are wrong-path requests.
REQ-021 pc_stall SHALL equal hazard_stall in IDLE and SQUASH, and SHALL be 0 in REDIRECT (a redirect overrides a stall).
REQ-022 Simultaneous br_req and hazard_stall in IDLE: the redirect SHALL still be accepted; pc_stall follows hazard_stall in that cycle.
REQ-023 Outside REDIRECT, new_pc SHALL hold its last latched value; new_pc SHALL be 0 after reset.
REQ-024 All outputs SHALL be registered; latency from br_req to branch_taken is one cycle.
REQ-025 A request seen in the last SQUASH cycle SHALL be ignored; the first request accepted is one arriving in IDLE.

Reset
REQ-026 While rst==0 at a clock edge, the FSM SHALL enter IDLE and the counter and latched target SHALL be 0.
REQ-027 Reset values SHALL be: branch_taken=0, new_pc=0, pc_stall=0, squash=0, busy=0.
REQ-028 A reset asserted mid-redirect or mid-squash SHALL abort the sequence with no further branch_taken or squash.

Configuration
REQ-029 With macro BRANCH_REDIRECT_PERF_EN defined, the block SHALL add output redirect_count (32 bits).
REQ-030 redirect_count SHALL increment once per REDIRECT cycle, wrap from 0xFFFFFFFF to 0, and reset to 0.
REQ-031 With BRANCH_REDIRECT_PERF_EN undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package vliw_ctrl_pkg SHALL hold the FSM state enum, the default for NUM_SLOTS and the 32-bit address typedef.
REQ-033 Sub-module prio_arbiter (one-hot grant plus index, parameterised by NUM_SLOTS) SHALL perform the arbitration.

Verification
REQ-034 br_req=4'b0100, br_target[2]=0x00000100 in IDLE -> next cycle branch_taken=1 and new_pc=0x100; squash=1 for 2 cycles; busy=0 after 2 cycles.
REQ-035 br_req=4'b1010 with targets 0x200 (slot 1) and 0x800 (slot 3) -> new_pc=0x200, exactly one branch_taken pulse.
REQ-036 br_req=4'b0001 held high through REDIRECT and SQUASH -> no second branch_taken until IDLE; a second pulse follows on the first IDLE cycle.
REQ-037 hazard_stall=1 together with br_req=4'b0001 -> pc_stall=0 in the REDIRECT cycle, then pc_stall=1 in SQUASH.
REQ-038 rst driven 0 in the REDIRECT cycle -> next edge: all outputs 0, busy=0, no squash.
REQ-039 With BRANCH_REDIRECT_PERF_EN defined, 3 redirects -> redirect_count=3; preload 0xFFFFFFFF, then one redirect -> redirect_count=0.
